// File: rtl/gba_audio_pkg.sv
// Shared types and sizes for the direct-sound audio blocks.
// The FIFO constants describe the 32-byte GBA sound FIFO.
package gba_audio_pkg;

    localparam int DS_FIFO_DEPTH  = 8;
    localparam int DS_FIFO_WIDTH  = 32;
    localparam int DS_FIFO_SIZE_W = 4;

    typedef enum logic {
        STAGE_EMPTY = 1'b0,
        STAGE_LOW   = 1'b1
    } ds_stage_t;

    typedef logic [31:0] ds_word_t;

endpackage

// File: rtl/ds_fifo_writer_if.sv
// Bus-write and consumer-side signals of one direct-sound FIFO.
// master = the bus and the sound channel; slave = the FIFO itself.
interface ds_fifo_writer_if;
    import gba_audio_pkg::*;

    logic                      wr_en;
    logic                      wr_half;
    logic                      wr_hi;
    ds_word_t                  wr_data;
    logic                      FIFO_re;
    logic                      FIFO_clr;
    logic [DS_FIFO_SIZE_W-1:0] FIFO_size;
    ds_word_t                  FIFO_val;
    logic                      full;
    logic                      empty;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output wr_en, wr_half, wr_hi, wr_data, FIFO_re, FIFO_clr,
        input  FIFO_size, FIFO_val, full, empty, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_half, wr_hi, wr_data, FIFO_re, FIFO_clr,
        output FIFO_size, FIFO_val, full, empty, overflow, underflow
    );
endinterface

// File: rtl/ds_fifo_core.sv
// Generic circular buffer with push/pop/clear, occupancy count and a
// show-ahead head word that reads as zero while empty.
module ds_fifo_core #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 32,
    parameter int SIZE_W = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    input  logic              clr,
    output logic [SIZE_W-1:0] count,
    output logic [WIDTH-1:0]  head,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [SIZE_W-1:0] count_reg;
    logic              pop_eff;
    logic              push_eff;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == SIZE_W'(DEPTH));
    assign pop_eff  = pop & ~empty;
    // A push into a full buffer is only safe when a pop frees a slot.
    assign push_eff = push & (~full | pop_eff);

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (push_eff && !clr) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_eff) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_eff)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_reg <= count_reg + SIZE_W'(1);
                2'b01:   count_reg <= count_reg - SIZE_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = empty ? '0 : mem[rd_ptr_reg];
endmodule

// File: rtl/ds_fifo_writer.sv
// Write side of a direct-sound FIFO: assembles halfword bus writes into
// words, stores them, and keeps sticky overflow/underflow flags.
module ds_fifo_writer
    import gba_audio_pkg::*;
#(
    parameter int DEPTH  = DS_FIFO_DEPTH,
    parameter int WIDTH  = DS_FIFO_WIDTH,
    parameter int SIZE_W = DS_FIFO_SIZE_W
) (
    input  logic              clock,
    input  logic              reset_n,
    ds_fifo_writer_if.slave   bus
);
    ds_stage_t   stage_reg;
    logic [15:0] staging_reg;
    logic        overflow_reg;
    logic        underflow_reg;

    logic        commit;
    ds_word_t    commit_data;
    logic        core_full;
    logic        core_empty;

    // Word writes and upper-half writes both commit; a lower half only stages.
    assign commit      = bus.wr_en & (~bus.wr_half | bus.wr_hi);
    assign commit_data = bus.wr_half ? {bus.wr_data[31:16], staging_reg} : bus.wr_data;

    ds_fifo_core #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .SIZE_W (SIZE_W)
    ) u_core (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (commit & ~bus.FIFO_clr),
        .push_data (commit_data),
        .pop       (bus.FIFO_re & ~bus.FIFO_clr),
        .clr       (bus.FIFO_clr),
        .count     (bus.FIFO_size),
        .head      (bus.FIFO_val),
        .full      (core_full),
        .empty     (core_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stage_reg     <= STAGE_EMPTY;
            staging_reg   <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (bus.FIFO_clr) begin
            stage_reg     <= STAGE_EMPTY;
            staging_reg   <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            // Full always implies non-empty, so a coincident pop frees a slot.
            if (commit && core_full && !bus.FIFO_re) overflow_reg <= 1'b1;
            if (bus.FIFO_re && core_empty)           underflow_reg <= 1'b1;
            if (bus.wr_en) begin
                if (bus.wr_half && !bus.wr_hi) begin
                    staging_reg <= bus.wr_data[15:0];
                    stage_reg   <= STAGE_LOW;
                end else begin
                    stage_reg   <= STAGE_EMPTY;
                end
            end
        end
    end

    assign bus.full      = core_full;
    assign bus.empty     = core_empty;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_ds_fifo_writer.sv
// Directed plus randomized bench for ds_fifo_writer against a queue-based model.
module tb_ds_fifo_writer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    ds_fifo_writer_if bus ();

    ds_fifo_writer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a FIFO of words, the staged low half and the sticky flags.
    logic [31:0] mq[$];
    logic [15:0] m_stage;
    bit          m_ovf;
    bit          m_unf;
    logic [31:0] last_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_stage = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_val;
        exp_val = (mq.size() != 0) ? mq[0] : 32'h0;
        chk({tag, ".size"},  32'(bus.FIFO_size), 32'(mq.size()));
        chk({tag, ".val"},   bus.FIFO_val, exp_val);
        chk({tag, ".full"},  32'(bus.full), 32'(mq.size() == 8));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(mq.size() == 0));
        chk({tag, ".ovf"},   32'(bus.overflow), 32'(m_ovf));
        chk({tag, ".unf"},   32'(bus.underflow), 32'(m_unf));
    endtask

    task automatic model_step(input bit we, input bit half, input bit hi,
                              input logic [31:0] d, input bit re, input bit clr);
        logic [31:0] word;
        bit          do_commit;
        if (clr) begin
            model_reset();
            return;
        end
        do_commit = 1'b0;
        word = d;
        if (we) begin
            if (!half) begin
                do_commit = 1'b1;
            end else if (hi) begin
                do_commit = 1'b1;
                word = {d[31:16], m_stage};
            end else begin
                m_stage = d[15:0];
            end
        end
        if (re) begin
            if (mq.size() == 0) m_unf = 1'b1;
            else void'(mq.pop_front());
        end
        if (do_commit) begin
            if (mq.size() < 8) mq.push_back(word);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input string tag, input bit we, input bit half, input bit hi,
                        input logic [31:0] d, input bit re, input bit clr);
        bus.wr_en = we;
        bus.wr_half = half;
        bus.wr_hi = hi;
        bus.wr_data = d;
        bus.FIFO_re = re;
        bus.FIFO_clr = clr;
        last_val = bus.FIFO_val;
        @(posedge clock);
        model_step(we, half, hi, d, re, clr);
        #1;
        bus.wr_en = 1'b0;
        bus.wr_half = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_data = '0;
        bus.FIFO_re = 1'b0;
        bus.FIFO_clr = 1'b0;
        check_all(tag);
        $display("step %-10s we=%0d half=%0d hi=%0d data=%h re=%0d clr=%0d -> size=%0d val=%h ovf=%0d unf=%0d",
                 tag, we, half, hi, d, re, clr, bus.FIFO_size, bus.FIFO_val,
                 bus.overflow, bus.underflow);
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_half = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_data = '0;
        bus.FIFO_re = 1'b0;
        bus.FIFO_clr = 1'b0;
        model_reset();

        #12;
        check_all("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Fill with eight words, then one more to overflow.
        for (int i = 1; i <= 8; i++)
            step("fill", 1, 0, 0, 32'h11111111 * i, 0, 0);
        chk("fill.head", bus.FIFO_val, 32'h11111111);
        step("overflow", 1, 0, 0, 32'hDEADBEEF, 0, 0);
        chk("overflow.flag", 32'(bus.overflow), 32'd1);

        // Pop and write together while full, then drain.
        step("full_rw", 1, 0, 0, 32'h99999999, 1, 0);
        chk("full_rw.size", 32'(bus.FIFO_size), 32'd8);
        for (int i = 0; i < 8; i++)
            step("drain", 0, 0, 0, 32'h0, 1, 0);
        chk("drain.last", last_val, 32'h99999999);

        // Pop and write together while empty.
        step("empty_rw", 1, 0, 0, 32'h12345678, 1, 0);
        chk("empty_rw.val", bus.FIFO_val, 32'h12345678);
        step("clr", 0, 0, 0, 32'h0, 0, 1);

        // Halfword assembly.
        step("half_lo", 1, 1, 0, 32'h0000AAAA, 0, 0);
        step("half_hi", 1, 1, 1, 32'hBBBB0000, 0, 0);
        chk("half.val", bus.FIFO_val, 32'hBBBBAAAA);
        step("clr", 0, 0, 0, 32'h0, 0, 1);

        // Clear beats a coincident write and discards the staged half.
        for (int i = 0; i < 5; i++)
            step("pre_clr", 1, 0, 0, 32'hA0000000 + 32'(i), 0, 0);
        step("stage", 1, 1, 0, 32'h00005555, 0, 0);
        step("clr_wr", 1, 0, 0, 32'h77777777, 0, 1);
        step("hi_clr", 1, 1, 1, 32'hCAFE0000, 0, 0);
        chk("hi_clr.val", bus.FIFO_val, 32'hCAFE0000);

        // Asynchronous reset between edges.
        step("clr", 0, 0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 3; i++)
            step("pre_rst", 1, 0, 0, 32'hC0000000 + 32'(i), 0, 0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #3;
        reset_n = 1'b1;
        step("post_rst", 1, 0, 0, 32'h5A5A5A5A, 0, 0);
        chk("post_rst.size", 32'(bus.FIFO_size), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit clr_r;
            clr_r = ($urandom_range(0, 99) < 3);
            step("rand", ($urandom_range(0, 99) < 60), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom, ($urandom_range(0, 99) < 40), clr_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
